// File: rtl/round_mix_stage.sv
// AES round tail: ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey
// on a valid/ready pipeline. Define ROUND_MIX_SINGLE_STAGE_EN to collapse it to one register stage.
module round_mix_stage #(
    parameter int ROUND_ID_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           w0,
    input  logic [31:0]           w1,
    input  logic [31:0]           w2,
    input  logic [31:0]           w3,
    input  logic [31:0]           key0,
    input  logic [31:0]           key1,
    input  logic [31:0]           key2,
    input  logic [31:0]           key3,
    input  logic                  last_round,
    input  logic [ROUND_ID_W-1:0] round_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           w_0,
    output logic [31:0]           w_1,
    output logic [31:0]           w_2,
    output logic [31:0]           w_3,
    output logic [ROUND_ID_W-1:0] round_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // State is packed {col0, col1, col2, col3}; row 0 is the top byte of each column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + row) % 4) - 8*row -: 8];
            end
        end
        return r;
    endfunction

    logic [127:0] in_state;
    logic [127:0] in_key;
    logic [127:0] shifted;
    logic [127:0] mixed;

    assign in_state = {w0, w1, w2, w3};
    assign in_key   = {key0, key1, key2, key3};
    assign shifted  = shift_rows(in_state);
    assign mixed    = last_round ? shifted
                                 : {mix_column(shifted[127:96]), mix_column(shifted[95:64]),
                                    mix_column(shifted[63:32]),  mix_column(shifted[31:0])};

    logic                  out_valid_q;
    logic [127:0]          out_data_q;
    logic [ROUND_ID_W-1:0] out_tag_q;
    logic                  s2_load;
    logic                  out_src_valid;
    logic [127:0]          out_data_d;
    logic [ROUND_ID_W-1:0] out_tag_d;

    assign s2_load = !out_valid_q || out_ready;

`ifdef ROUND_MIX_SINGLE_STAGE_EN
    assign in_ready      = s2_load;
    assign out_src_valid = in_valid;
    assign out_data_d    = mixed ^ in_key;
    assign out_tag_d     = round_in;
`else
    logic                  s1_valid_q;
    logic [127:0]          s1_mix_q;
    logic [127:0]          s1_key_q;
    logic [ROUND_ID_W-1:0] s1_tag_q;
    logic                  s1_load;

    assign s1_load       = !s1_valid_q || s2_load;
    assign in_ready      = s1_load;
    assign out_src_valid = s1_valid_q;
    assign out_data_d    = s1_mix_q ^ s1_key_q;
    assign out_tag_d     = s1_tag_q;

    // NOTE: data registers are reset too so nothing downstream ever sees X, even though
    // only the valid bit decides whether a slot's contents mean anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mix_q   <= '0;
            s1_key_q   <= '0;
            s1_tag_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mix_q <= mixed;
                s1_key_q <= in_key;
                s1_tag_q <= round_in;
            end
        end
    end
`endif

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, which is
    // what lets S1->S2 and a new input accept happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (s2_load) begin
            out_valid_q <= out_src_valid;
            if (out_src_valid) begin
                out_data_q <= out_data_d;
                out_tag_q  <= out_tag_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign w_0       = out_data_q[127:96];
    assign w_1       = out_data_q[95:64];
    assign w_2       = out_data_q[63:32];
    assign w_3       = out_data_q[31:0];
    assign round_out = out_tag_q;

endmodule

// File: tb/tb_round_mix_stage.sv
// Self-checking bench for round_mix_stage: directed FIPS-197 vectors, backpressure,
// streaming, mid-flight reset and randomized traffic against a byte-level AES model.
module tb_round_mix_stage;

    localparam int RW = 4;
`ifdef ROUND_MIX_SINGLE_STAGE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_state;
    logic [127:0]  in_key;
    logic          last_round;
    logic [RW-1:0] round_in;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   w_0, w_1, w_2, w_3;
    logic [RW-1:0] round_out;
    logic [127:0]  out_state;

    always #5 clk = ~clk;

    assign out_state = {w_0, w_1, w_2, w_3};

    round_mix_stage #(.ROUND_ID_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w0        (in_state[127:96]),
        .w1        (in_state[95:64]),
        .w2        (in_state[63:32]),
        .w3        (in_state[31:0]),
        .key0      (in_key[127:96]),
        .key1      (in_key[95:64]),
        .key2      (in_key[63:32]),
        .key3      (in_key[31:0]),
        .last_round(last_round),
        .round_in  (round_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_0       (w_0),
        .w_1       (w_1),
        .w_2       (w_2),
        .w_3       (w_3),
        .round_out (round_out)
    );

    typedef struct packed {
        logic [127:0]  data;
        logic [RW-1:0] tag;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            n_in = 0;
    int            n_out = 0;
    logic          last_acc;
    logic          hold_pend = 1'b0;
    logic [127:0]  hold_data;
    logic [RW-1:0] hold_tag;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] kk,
                                               input logic last);
        logic [7:0]   b [4][4];
        logic [7:0]   sh[4][4];
        logic [7:0]   m [4][4];
        logic [7:0]   cf[4];
        logic [127:0] r;
        cf = '{8'd2, 8'd3, 8'd1, 8'd1};
        r  = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                b[c][row] = s[127 - 32*c - 8*row -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                sh[c][row] = b[(c + row) % 4][row];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                m[c][row] = 8'h00;
                for (int k = 0; k < 4; k++)
                    m[c][row] = m[c][row] ^ gmul(cf[(k - row + 4) % 4], sh[c][k]);
            end
        if (last) m = sh;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 32*c - 8*row -: 8] = m[c][row] ^ kk[127 - 32*c - 8*row -: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_input(input logic [RW-1:0] tag);
        in_state   = {$urandom, $urandom, $urandom, $urandom};
        in_key     = {$urandom, $urandom, $urandom, $urandom};
        last_round = ($urandom_range(0, 3) == 0);
        round_in   = tag;
    endtask

    // One clock: scoreboard the pre-edge handshake, then advance to just after the edge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        if (hold_pend) begin
            check("hold_valid", {127'd0, out_valid}, 128'd1);
            check("hold_data", out_state, hold_data);
            check("hold_tag", {124'd0, round_out}, {124'd0, hold_tag});
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_state;
        hold_tag  = round_out;
        if (out_valid && out_ready) begin
            check("out_expected", {127'd0, exp_q.size() != 0}, 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", out_state, e.data);
                check("out_tag", {124'd0, round_out}, {124'd0, e.tag});
            end
            n_out++;
        end
        if (last_acc) begin
            e.data = ref_round(in_state, in_key, last_round);
            e.tag  = round_in;
            exp_q.push_back(e);
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && (exp_q.size() != 0 || out_valid); g++) tick();
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    int lat;
    int idx;
    int base;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_state   = '0;
        in_key     = '0;
        last_round = 1'b0;
        round_in   = '0;
        out_ready  = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_state, 128'd0);
        check("rst_round_out", {124'd0, round_out}, 128'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);

        // FIPS-197 round 1 with latency measurement
        in_state   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
        in_key     = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        last_round = 1'b0;
        round_in   = 4'd1;
        in_valid   = 1'b1;
        tick();
        check("fips_accept", {127'd0, last_acc}, 128'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("fips_latency", 128'(lat), 128'(LAT));
        check("fips_data", out_state, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
        check("fips_tag", {124'd0, round_out}, 128'd1);
        tick();

        // Final round: MixColumns bypassed
        in_state   = 128'h00112233_44556677_8899aabb_ccddeeff;
        in_key     = '0;
        last_round = 1'b1;
        round_in   = 4'd14;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < 10 && !out_valid; g++) tick();
        check("final_data", out_state, 128'h0055aaff_4499ee33_88dd2277_cc1166bb);
        check("final_tag", {124'd0, round_out}, 128'd14);
        drain();

        // Backpressure: 4 stalled cycles, stall depth equals pipeline depth
        base      = n_out;
        out_ready = 1'b0;
        idx       = 0;
        rand_input(4'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last_acc) begin
                idx++;
                rand_input(4'(idx + 1));
            end
        end
        check("bp_accepts", 128'(idx), 128'(LAT));
        check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1;
        for (int g = 0; g < 30 && idx < 5; g++) begin
            tick();
            if (last_acc) begin
                idx++;
                rand_input(4'(idx + 1));
            end
        end
        drain();
        check("bp_out_count", 128'(n_out - base), 128'd5);

        // Full-rate streaming
        base      = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_input(4'(i));
            in_valid = 1'b1;
            tick();
            check("stream_accept", {127'd0, last_acc}, 128'd1);
            check("stream_out_valid", {127'd0, out_valid}, {127'd0, i >= LAT - 1});
        end
        drain();
        check("stream_out_count", 128'(n_out - base), 128'd8);

        // Reset mid-flight discards everything in the pipeline
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_input(4'd7);
        tick();
        rand_input(4'd8);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mrst_out_data", out_state, 128'd0);
        check("mrst_round_out", {124'd0, round_out}, 128'd0);
        exp_q.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mrst_in_ready", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_stale", {127'd0, out_valid}, 128'd0);
        end

        // Randomized traffic against the model
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 60; i++) begin
            if (!in_valid || last_acc) rand_input(4'($urandom_range(0, 15)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        check("rand_in_out_count", 128'(n_out), 128'(n_in));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
